// File: rtl/noc_sram_pkg.sv
// Shared types and packet constants for the SoClet SRAM port arbiter.
// Packet layout: [31:24] CMD, [23:16] DATA, [15:0] COORD.
package noc_sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        ERR   = 2'd2
    } arb_state_t;

    localparam logic [7:0] CMD_SRAM_WRITE = 8'hA1;

    localparam int PKT_CMD_HI   = 31;
    localparam int PKT_CMD_LO   = 24;
    localparam int PKT_DATA_HI  = 23;
    localparam int PKT_DATA_LO  = 16;
    localparam int PKT_COORD_HI = 15;
    localparam int PKT_COORD_LO = 0;

    function automatic logic is_sram_write(logic [31:0] pkt);
        return pkt[PKT_CMD_HI:PKT_CMD_LO] == CMD_SRAM_WRITE;
    endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping at N_REQ.
module sram_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             valid,
    output logic [PW-1:0]    idx
);

    logic [PW:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is kept.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(N_REQ)) begin
                cand = cand - (PW+1)'(N_REQ);
            end
            if (req[cand[PW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin Wishbone arbiter in front of the SoClet SRAM wrapper, with a
// per-transfer watchdog that returns an error pulse to the bus owner.
module sram_arbiter
    import noc_sram_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  s_cyc_i,
    input  logic [N_REQ-1:0]  s_stb_i,
    input  logic [N_REQ-1:0]  s_we_i,
    input  logic [32*N_REQ-1:0] s_adr_i,
    input  logic [32*N_REQ-1:0] s_dat_i,
    output logic [N_REQ-1:0]  s_ack_o,
    output logic [N_REQ-1:0]  s_err_o,
    output logic              m_cyc_o,
    output logic              m_stb_o,
    output logic              m_we_o,
    output logic [31:0]       m_adr_o,
    output logic [31:0]       m_dat_o,
    input  logic              m_ack_i,
    output logic [N_REQ-1:0]  grant_o
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);

    arb_state_t    state_q;
    logic [PW-1:0] owner_q;
    logic [PW-1:0] rr_ptr_q;
    logic [CW-1:0] wd_cnt_q;

    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] ptr_d;

    logic [N_REQ-1:0][31:0] adr_arr;
    logic [N_REQ-1:0][31:0] dat_arr;

    assign adr_arr = s_adr_i;
    assign dat_arr = s_dat_i;

    sram_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req   (s_cyc_i),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign ptr_d = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

    // Master port and responses mirror the owner with no pipeline stage.
    always_comb begin
        m_cyc_o = 1'b0;
        m_stb_o = 1'b0;
        m_we_o  = 1'b0;
        m_adr_o = '0;
        m_dat_o = '0;
        s_ack_o = '0;
        s_err_o = '0;
        grant_o = '0;
        if (state_q != IDLE) begin
            grant_o[owner_q] = 1'b1;
            m_cyc_o = s_cyc_i[owner_q];
            m_we_o  = s_we_i[owner_q];
            m_adr_o = adr_arr[owner_q];
            m_dat_o = dat_arr[owner_q];
            if (state_q == OWNED) begin
                m_stb_o = s_stb_i[owner_q];
                s_ack_o[owner_q] = m_ack_i;
            end else begin
                s_err_o[owner_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wd_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wd_cnt_q <= '0;
                    if (pick_valid) begin
                        owner_q  <= pick_idx;
                        rr_ptr_q <= ptr_d;
                        state_q  <= OWNED;
                    end
                end
                OWNED: begin
                    if (!s_cyc_i[owner_q]) begin
                        wd_cnt_q <= '0;
                        state_q  <= IDLE;
                    end else if (m_stb_o && !m_ack_i) begin
                        // The stall that would bring the count to TIMEOUT-1 trips.
                        if (wd_cnt_q == CW'(TIMEOUT - 2)) begin
                            wd_cnt_q <= '0;
                            state_q  <= ERR;
                        end else begin
                            wd_cnt_q <= wd_cnt_q + 1'b1;
                        end
                    end else begin
                        wd_cnt_q <= '0;
                    end
                end
                ERR: begin
                    wd_cnt_q <= '0;
                    state_q  <= s_cyc_i[owner_q] ? OWNED : IDLE;
                end
                default: begin
                    wd_cnt_q <= '0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, single write, round-robin order,
// bus lock, watchdog and ack-versus-timeout.
module tb_sram_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   cyc, stb, we;
    logic [127:0] adr, dat;
    logic [3:0]   s_ack, s_err, grant;
    logic         m_cyc, m_stb, m_we, ack;
    logic [31:0]  m_adr, m_dat;

    int n_cmp;
    int n_bad;

    sram_arbiter #(
        .N_REQ   (4),
        .TIMEOUT (15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_cyc_i (cyc),
        .s_stb_i (stb),
        .s_we_i  (we),
        .s_adr_i (adr),
        .s_dat_i (dat),
        .s_ack_o (s_ack),
        .s_err_o (s_err),
        .m_cyc_o (m_cyc),
        .m_stb_o (m_stb),
        .m_we_o  (m_we),
        .m_adr_o (m_adr),
        .m_dat_o (m_dat),
        .m_ack_i (ack),
        .grant_o (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [79:0] outs;
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        outs = {grant, m_cyc, m_stb, m_we, m_adr, m_dat, s_ack, s_err};
        n_cmp++;
        if (outs !== 80'd0) begin
            n_bad++;
            $display("FAIL reset_outs: got %h want 0", outs);
        end
        rst = 1'b1;
        cyc = 4'b0001;
        stb = 4'b0001;
        tick();
        @(negedge clk);
        n_cmp++;
        if ({grant, m_stb} !== 5'b0001_1) begin
            n_bad++;
            $display("FAIL pre_reset_own: got %b want 00011", {grant, m_stb});
        end
        #2;
        rst = 1'b0;
        ack = 1'b1;
        #1;
        outs = {grant, m_cyc, m_stb, m_we, m_adr, m_dat, s_ack, s_err};
        n_cmp++;
        if (outs !== 80'd0) begin
            n_bad++;
            $display("FAIL reset_midxfer: got %h want 0", outs);
        end
        cyc = 4'b0000;
        stb = 4'b0000;
        ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_idle_grant: got %b want 0000", grant);
        end
        cyc = 4'b0011;
        tick();
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_ptr_zero: got %b want 0001", grant);
        end
        cyc = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_single_write();
        adr = {4{32'hDEAD_BEEF}};
        dat = {4{32'h1234_5678}};
        adr[64 +: 32] = 32'h0000_001F;
        dat[64 +: 32] = 32'hA15A_0003;
        cyc = 4'b0100;
        stb = 4'b0100;
        we  = 4'b0100;
        tick();
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0100) begin
            n_bad++;
            $display("FAIL write_grant: got %b want 0100", grant);
        end
        n_cmp++;
        if ({m_cyc, m_stb, m_we, m_adr, m_dat} !== {3'b111, 32'h1F, 32'hA15A_0003}) begin
            n_bad++;
            $display("FAIL write_mirror: got %b%b%b %h %h want 111 0000001f a15a0003",
                     m_cyc, m_stb, m_we, m_adr, m_dat);
        end
        ack = 1'b1;
        #1;
        n_cmp++;
        if ({s_ack, s_err} !== 8'b0100_0000) begin
            n_bad++;
            $display("FAIL write_ack_route: got %b want 01000000", {s_ack, s_err});
        end
        @(posedge clk);
        #1;
        cyc = 4'b0000;
        stb = 4'b0000;
        we  = 4'b0000;
        ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({s_ack, m_cyc} !== 5'b0100_0) begin
            n_bad++;
            $display("FAIL release_ack: got %b want 01000", {s_ack, m_cyc});
        end
        tick();
        ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0000) begin
            n_bad++;
            $display("FAIL release_idle: got %b want 0000", grant);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] want;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        cyc = 4'b1111;
        stb = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            want = 4'b0001 << (i % 4);
            tick();
            @(negedge clk);
            n_cmp++;
            if (grant !== want) begin
                n_bad++;
                $display("FAIL rr_grant_%0d: got %b want %b", i, grant, want);
            end
            ack = 1'b1;
            #1;
            n_cmp++;
            if (s_ack !== want) begin
                n_bad++;
                $display("FAIL rr_ack_%0d: got %b want %b", i, s_ack, want);
            end
            tick();
            cyc[i % 4] = 1'b0;
            stb[i % 4] = 1'b0;
            ack = 1'b0;
            tick();
            @(negedge clk);
            n_cmp++;
            if (grant !== 4'b0000) begin
                n_bad++;
                $display("FAIL rr_gap_%0d: got %b want 0000", i, grant);
            end
            if (i == 0) begin
                cyc[0] = 1'b1;
                stb[0] = 1'b1;
            end
        end
    endtask

    task automatic test_bus_lock();
        cyc = 4'b1010;
        stb = 4'b1010;
        tick();
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0010) begin
            n_bad++;
            $display("FAIL lock_grant1: got %b want 0010", grant);
        end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            n_cmp++;
            if ({s_ack, m_stb} !== 5'b0000_1) begin
                n_bad++;
                $display("FAIL lock_wait_%0d: got %b want 00001", s, {s_ack, m_stb});
            end
            tick();
            ack = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (s_ack !== 4'b0010) begin
                n_bad++;
                $display("FAIL lock_ack_%0d: got %b want 0010", s, s_ack);
            end
            tick();
            ack = 1'b0;
        end
        cyc[1] = 1'b0;
        stb[1] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0010) begin
            n_bad++;
            $display("FAIL lock_hold: got %b want 0010", grant);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0000) begin
            n_bad++;
            $display("FAIL lock_gap: got %b want 0000", grant);
        end
        tick();
        ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({grant, s_ack} !== 8'b1000_1000) begin
            n_bad++;
            $display("FAIL lock_grant3: got %b want 10001000", {grant, s_ack});
        end
        tick();
        ack = 1'b0;
        cyc = 4'b0000;
        stb = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_watchdog();
        cyc = 4'b0001;
        stb = 4'b0001;
        tick();
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({s_err, m_stb} !== 5'b0000_1) begin
                n_bad++;
                $display("FAIL wd_stall_%0d: got %b want 00001", k, {s_err, m_stb});
            end
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if ({s_err, m_stb, m_cyc} !== 6'b0001_01) begin
            n_bad++;
            $display("FAIL wd_err: got %b want 000101", {s_err, m_stb, m_cyc});
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({grant, s_err, m_stb} !== 9'b0001_0000_1) begin
            n_bad++;
            $display("FAIL wd_resume: got %b want 000100001", {grant, s_err, m_stb});
        end
        cyc = 4'b0000;
        stb = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_ack_vs_timeout();
        cyc = 4'b0010;
        stb = 4'b0010;
        tick();
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            n_cmp++;
            if (s_err !== 4'b0000) begin
                n_bad++;
                $display("FAIL avt_stall_%0d: got %b want 0000", k, s_err);
            end
            tick();
        end
        ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({s_ack, s_err} !== 8'b0010_0000) begin
            n_bad++;
            $display("FAIL avt_ack: got %b want 00100000", {s_ack, s_err});
        end
        tick();
        ack = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({s_err, m_stb} !== 5'b0000_1) begin
                n_bad++;
                $display("FAIL avt_restart_%0d: got %b want 00001", k, {s_err, m_stb});
            end
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if (s_err !== 4'b0010) begin
            n_bad++;
            $display("FAIL avt_late_err: got %b want 0010", s_err);
        end
        tick();
        cyc = 4'b0000;
        stb = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        cyc = '0;
        stb = '0;
        we  = '0;
        adr = '0;
        dat = '0;
        ack = 1'b0;
        test_reset();
        test_single_write();
        test_simultaneous();
        test_bus_lock();
        test_watchdog();
        test_ack_vs_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
